// File: rtl/message_scroller_pkg.sv
// message_scroller_pkg: constants and types shared by the scroller, its timer
// and neighbouring display blocks (FSM, LED decoder).
//   MSG_LEN_DEF  default message buffer depth (characters)
//   DIGITS       number of display digits driven from the window
//   CHAR_W       width of one character code
//   scroll_state_e  SCROLL / PAUSED run state
//   RESET_MSG    power-on message, nibble i holds character code i
package message_scroller_pkg;

    localparam int unsigned MSG_LEN_DEF = 16;
    localparam int unsigned DIGITS      = 4;
    localparam int unsigned CHAR_W      = 4;

    typedef logic [CHAR_W-1:0] char_t;

    typedef enum logic {
        SCROLL = 1'b0,
        PAUSED = 1'b1
    } scroll_state_e;

    // Identity message: character i reads back as code i.
    localparam logic [16*CHAR_W-1:0] RESET_MSG = 64'hFEDC_BA98_7654_3210;

endpackage

// File: rtl/message_scroller_if.sv
// message_scroller_if: single-character write port into the message buffer.
//   wr_valid  write request
//   wr_addr   buffer index, log2(MSG_LEN) bits
//   wr_data   character code
//   wr_ready  write accepted this cycle
// master = writer, slave = message_scroller.
interface message_scroller_if
    import message_scroller_pkg::*;
#(
    parameter int unsigned MSG_LEN = MSG_LEN_DEF
);
    localparam int unsigned AW = $clog2(MSG_LEN);

    logic          wr_valid;
    logic [AW-1:0] wr_addr;
    char_t         wr_data;
    logic          wr_ready;

    modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);

endinterface

// File: rtl/message_scroller_scroll_timer.sv
// scroll_timer: free-running step counter with pause/restart control.
//   clk, reset  clock and synchronous active-high reset
//   pause       level; freezes the count while high
//   restart     pulse; clears the count on the next edge
//   step        one-cycle pulse when a scroll step is committed
module scroll_timer
    import message_scroller_pkg::*;
#(
    parameter int unsigned SCROLL_CYCLES = 50000000
) (
    input  logic clk,
    input  logic reset,
    input  logic pause,
    input  logic restart,
    output logic step
);

    localparam int unsigned CW = $clog2(SCROLL_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(SCROLL_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    scroll_state_e state_q, state_d;

    // Next count/state. step depends on the live pause/restart inputs so that
    // a pause or restart in the terminal cycle suppresses the step itself.
    // At terminal count with pause high the count holds so no step is lost.
    always_comb begin
        cnt_d   = cnt_q;
        state_d = pause ? PAUSED : SCROLL;
        step    = 1'b0;
        if (restart) begin
            cnt_d = '0;
        end else if (state_q == SCROLL) begin
            if (cnt_q != CNT_LAST) begin
                cnt_d = cnt_q + CW'(1);
            end else if (!pause) begin
                cnt_d = '0;
                step  = !reset;
            end
        end
    end

    // Count and run-state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            state_q <= SCROLL;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/message_scroller.sv
// message_scroller: scrolling 4-digit window over a writable message buffer.
//   clk, reset        clock and synchronous active-high reset
//   pause, restart    scroll control (see scroll_timer)
//   wr                buffer write port (slave side)
//   char3..char0      registered window characters, leftmost first
//   step              pulse in the cycle a scroll step is committed
module message_scroller
    import message_scroller_pkg::*;
#(
    parameter int unsigned MSG_LEN       = MSG_LEN_DEF,
    parameter int unsigned SCROLL_CYCLES = 50000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pause,
    input  logic                  restart,
    message_scroller_if.slave     wr,
    output char_t                 char3,
    output char_t                 char2,
    output char_t                 char1,
    output char_t                 char0,
    output logic                  step
);

    localparam int unsigned AW = $clog2(MSG_LEN);

    char_t         mem_q [MSG_LEN];
    logic [AW-1:0] ptr_q, ptr_d;
    logic [AW-1:0] win_idx [DIGITS];

    // Writes are refused only while reset is asserted.
    assign wr.wr_ready = !reset;

    scroll_timer #(
        .SCROLL_CYCLES (SCROLL_CYCLES)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .pause   (pause),
        .restart (restart),
        .step    (step)
    );

    // Window pointer; step is already suppressed by restart inside the timer.
    always_comb begin
        ptr_d = ptr_q;
        if (restart) begin
            ptr_d = '0;
        end else if (step) begin
            ptr_d = ptr_q + AW'(1);
        end
    end

    // Window indices wrap naturally because MSG_LEN is a power of two.
    always_comb begin
        for (int unsigned k = 0; k < DIGITS; k++) begin
            win_idx[k] = ptr_q + AW'(k);
        end
    end

    // Buffer, pointer and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
            for (int unsigned i = 0; i < MSG_LEN; i++) begin
                mem_q[i] <= RESET_MSG[i*CHAR_W +: CHAR_W];
            end
            char3 <= char_t'(0);
            char2 <= char_t'(1);
            char1 <= char_t'(2);
            char0 <= char_t'(3);
        end else begin
            ptr_q <= ptr_d;
            if (wr.wr_valid && wr.wr_ready) begin
                mem_q[wr.wr_addr] <= wr.wr_data;
            end
            char3 <= mem_q[win_idx[0]];
            char2 <= mem_q[win_idx[1]];
            char1 <= mem_q[win_idx[2]];
            char0 <= mem_q[win_idx[3]];
        end
    end

endmodule

// File: tb/tb_message_scroller.sv
// tb_message_scroller: directed scenarios plus randomized run of
// message_scroller (MSG_LEN=16, SCROLL_CYCLES=4) against a reference model.
module tb_message_scroller;
    import message_scroller_pkg::*;

    localparam int unsigned ML = 16;
    localparam int unsigned SC = 4;

    logic  clk = 1'b0;
    logic  reset, pause, restart, step;
    char_t char3, char2, char1, char0;

    always #5 clk = ~clk;

    message_scroller_if #(.MSG_LEN(ML)) wr_if ();

    message_scroller #(
        .MSG_LEN       (ML),
        .SCROLL_CYCLES (SC)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .pause   (pause),
        .restart (restart),
        .wr      (wr_if),
        .char3   (char3),
        .char2   (char2),
        .char1   (char1),
        .char0   (char0),
        .step    (step)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: message contents, window start, elapsed cycles within
    // the current scroll period, and whether the display is frozen.
    logic [3:0] m_mem [ML];
    int         m_ptr;
    int         m_phase;
    bit         m_frozen;
    logic [3:0] m_ch [4];
    bit         m_valid = 1'b0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare live outputs mid-cycle against the model.
    task automatic half();
        logic exp_step;
        @(negedge clk);
        if (m_valid) begin
            exp_step = !reset && !restart && !m_frozen && !pause && (m_phase == SC - 1);
            chk("step", 16'(step), 16'(exp_step));
            chk("wr_ready", 16'(wr_if.wr_ready), 16'(!reset));
            chk("chars", {char3, char2, char1, char0},
                {m_ch[3], m_ch[2], m_ch[1], m_ch[0]});
        end
    endtask

    // Advance the model across the rising edge using the inputs of the cycle.
    task automatic edge_adv();
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < ML; i++) m_mem[i] = 4'(i);
            m_ptr = 0; m_phase = 0; m_frozen = 1'b0;
            m_ch[3] = 4'd0; m_ch[2] = 4'd1; m_ch[1] = 4'd2; m_ch[0] = 4'd3;
            m_valid = 1'b1;
        end else begin
            for (int k = 0; k < 4; k++) m_ch[k] = m_mem[(m_ptr + 3 - k) % ML];
            if (wr_if.wr_valid) m_mem[wr_if.wr_addr] = wr_if.wr_data;
            if (restart) begin
                m_ptr = 0; m_phase = 0;
            end else if (!m_frozen) begin
                if (m_phase < SC - 1) m_phase++;
                else if (!pause) begin
                    m_phase = 0;
                    m_ptr = (m_ptr + 1) % ML;
                end
            end
            m_frozen = pause;
        end
        #1;
    endtask

    task automatic cyc();
        half();
        edge_adv();
    endtask

    task automatic idle();
        pause = 1'b0; restart = 1'b0; reset = 1'b0;
        wr_if.wr_valid = 1'b0; wr_if.wr_addr = '0; wr_if.wr_data = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        cyc();
        do_reset();

        // Free run and wrap-around.
        for (int k = 1; k <= 66; k++) begin
            half();
            chk("fr_step", 16'(step), 16'(k % 4 == 0));
            if (k == 6)  chk("fr_first", {char3, char2, char1, char0}, 16'h1234);
            if (k == 58) chk("fr_wrap14", {char3, char2, char1, char0}, 16'hEF01);
            if (k == 66) chk("fr_wrap16", {char3, char2, char1, char0}, 16'h0123);
            edge_adv();
        end

        // Pause from cycle 2 to cycle 9.
        do_reset();
        for (int k = 1; k <= 14; k++) begin
            pause = (k >= 2 && k <= 9);
            half();
            chk("pa_step", 16'(step), 16'(k == 12));
            if (k <= 13) chk("pa_hold", {char3, char2, char1, char0}, 16'h0123);
            edge_adv();
        end
        pause = 1'b0;

        // Restart coinciding with terminal count at ptr = 5.
        do_reset();
        for (int k = 1; k <= 26; k++) begin
            restart = (k == 24);
            half();
            if (k == 24) chk("rs_step", 16'(step), 16'h0);
            if (k == 25) chk("rs_old", {char3, char2, char1, char0}, 16'h5678);
            if (k == 26) chk("rs_new", {char3, char2, char1, char0}, 16'h0123);
            edge_adv();
        end
        restart = 1'b0;

        // Write mem[4] = A in the cycle of the step to ptr = 1.
        do_reset();
        for (int k = 1; k <= 6; k++) begin
            wr_if.wr_valid = (k == 4); wr_if.wr_addr = 4'd4; wr_if.wr_data = 4'hA;
            half();
            if (k == 4) chk("ws_step", 16'(step), 16'h1);
            if (k == 6) chk("ws_chars", {char3, char2, char1, char0}, 16'h123A);
            edge_adv();
        end
        wr_if.wr_valid = 1'b0;

        // Mid-run reset with a write pending.
        wr_if.wr_valid = 1'b1; wr_if.wr_addr = 4'd2; wr_if.wr_data = 4'h7;
        cyc();
        wr_if.wr_valid = 1'b0;
        cyc(); cyc();
        reset = 1'b1;
        wr_if.wr_valid = 1'b1; wr_if.wr_addr = 4'd3; wr_if.wr_data = 4'hF;
        cyc();
        reset = 1'b0; wr_if.wr_valid = 1'b0;
        half();
        chk("mr_reset", {char3, char2, char1, char0}, 16'h0123);
        edge_adv();
        half();
        chk("mr_mem", {char3, char2, char1, char0}, 16'h0123);
        edge_adv();

        // Randomized run.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 7) == 0) pause = ~pause;
            restart        = ($urandom_range(0, 29) == 0);
            reset          = ($urandom_range(0, 249) == 0);
            wr_if.wr_valid = 1'($urandom_range(0, 1));
            wr_if.wr_addr  = 4'($urandom_range(0, ML - 1));
            wr_if.wr_data  = 4'($urandom_range(0, 15));
            cyc();
        end
        idle();
        cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
